// File: rtl/ps2_key_state_decoder.sv
// PS/2 keyboard receiver (scan code set 2) with a make/break decoder that
// keeps WASD and arrow keys as held-key level vectors for the animation stage.
// Also exposes the last good scan byte and a frame-error pulse for debug LEDs.
module ps2_key_state_decoder #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [3:0] wasd,
  output logic [3:0] arrows,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

  // One-hot wasd bit for a set-2 letter code, zero for anything else.
  function automatic logic [3:0] wasd_mask(input logic [7:0] code);
    case (code)
      8'h1D:   return 4'b0001;
      8'h1C:   return 4'b0010;
      8'h1B:   return 4'b0100;
      8'h23:   return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  // One-hot arrows bit for an E0-prefixed cursor code, zero otherwise.
  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    case (code)
      8'h75:   return 4'b0001;
      8'h6B:   return 4'b0010;
      8'h72:   return 4'b0100;
      8'h74:   return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] data_sync_r;
  logic                   clk_prev_r;
  logic                   ps2_clk_s;
  logic                   ps2_data_s;
  logic                   fall_s;
  logic [3:0]             bit_cnt_r;
  logic [9:0]             frame_r;
  logic [TW-1:0]          to_cnt_r;
  logic                   last_edge_s;
  logic                   frame_ok_s;
  logic                   accept_s;
  logic                   bad_frame_s;
  logic                   timeout_s;
  logic [7:0]             rx_byte_s;
  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [3:0]             wasd_nxt_s;
  logic [3:0]             arrows_nxt_s;

  assign ps2_clk_s   = clk_sync_r[SYNC_STAGES-1];
  assign ps2_data_s  = data_sync_r[SYNC_STAGES-1];
  assign fall_s      = clk_prev_r & ~ps2_clk_s;
  assign last_edge_s = fall_s && (bit_cnt_r == 4'd10);
  // After ten shifts: [0]=start, [8:1]=data LSB first, [9]=parity; stop is on the wire now.
  assign rx_byte_s   = frame_r[8:1];
  assign frame_ok_s  = (frame_r[0] == 1'b0) && (ps2_data_s == 1'b1) && odd_parity_ok(frame_r[9:1]);
  assign accept_s    = last_edge_s && frame_ok_s;
  assign bad_frame_s = last_edge_s && !frame_ok_s;
  // A falling edge always wins over the timeout, so the two never coincide.
  assign timeout_s   = !fall_s && (bit_cnt_r != 4'd0) && (to_cnt_r == TW'(TIMEOUT_CYCLES - 1));

  // Bring the asynchronous PS/2 lines into the CLOCK domain; idle level is high.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      clk_sync_r  <= {SYNC_STAGES{1'b1}};
      data_sync_r <= {SYNC_STAGES{1'b1}};
      clk_prev_r  <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], PS2_CLK};
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], PS2_DATA};
      clk_prev_r  <= ps2_clk_s;
    end
  end

  // Shift in one bit per falling edge and restart the bit count after the stop bit or a timeout.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      bit_cnt_r <= 4'd0;
      frame_r   <= 10'd0;
    end else if (fall_s) begin
      if (last_edge_s) begin
        bit_cnt_r <= 4'd0;
      end else begin
        bit_cnt_r <= bit_cnt_r + 4'd1;
        frame_r   <= {ps2_data_s, frame_r[9:1]};
      end
    end else if (timeout_s) begin
      bit_cnt_r <= 4'd0;
    end else begin
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Count idle cycles inside a frame so a stalled keyboard cannot wedge the receiver.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      to_cnt_r <= '0;
    end else if (fall_s || timeout_s || (bit_cnt_r == 4'd0)) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_r + TW'(1);
    end
  end

  // Decoder next state and key vectors; only a freshly accepted byte moves anything.
  always_comb begin
    state_nxt_s  = state_r;
    wasd_nxt_s   = wasd;
    arrows_nxt_s = arrows;
    if (accept_s) begin
      case (state_r)
        ST_IDLE: begin
          if (rx_byte_s == 8'hE0) begin
            state_nxt_s = ST_EXT;
          end else if (rx_byte_s == 8'hF0) begin
            state_nxt_s = ST_BRK;
          end else if ((rx_byte_s == 8'hAA) || (rx_byte_s == 8'h00) || (rx_byte_s == 8'hFF)) begin
            wasd_nxt_s   = 4'b0000;
            arrows_nxt_s = 4'b0000;
            state_nxt_s  = ST_IDLE;
          end else begin
            wasd_nxt_s  = wasd | wasd_mask(rx_byte_s);
            state_nxt_s = ST_IDLE;
          end
        end
        ST_EXT: begin
          if (rx_byte_s == 8'hF0) begin
            state_nxt_s = ST_EXT_BRK;
          end else begin
            arrows_nxt_s = arrows | arrow_mask(rx_byte_s);
            state_nxt_s  = ST_IDLE;
          end
        end
        ST_BRK: begin
          wasd_nxt_s  = wasd & ~wasd_mask(rx_byte_s);
          state_nxt_s = ST_IDLE;
        end
        ST_EXT_BRK: begin
          arrows_nxt_s = arrows & ~arrow_mask(rx_byte_s);
          state_nxt_s  = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Register decoder state, key vectors and the debug outputs.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_r     <= ST_IDLE;
      wasd        <= 4'b0000;
      arrows      <= 4'b0000;
      scan_code   <= 8'h00;
      scan_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      wasd        <= wasd_nxt_s;
      arrows      <= arrows_nxt_s;
      scan_valid  <= accept_s;
      frame_error <= bad_frame_s | timeout_s;
      if (accept_s) begin
        scan_code <= rx_byte_s;
      end else begin
        scan_code <= scan_code;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_state_decoder.sv
// Directed bench for ps2_key_state_decoder: bit-bangs PS/2 frames and checks
// scan bytes, pulse timing and the held-key vectors against hand-computed values.
module tb_ps2_key_state_decoder;

  localparam int TO = 200;   // short timeout so the stall test stays quick
  localparam int HB = 8;     // PS/2 half bit period in system clocks

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] wasd;
  logic [3:0] arrows;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_error;

  int n_cmp = 0;
  int n_err = 0;
  int sv_cnt = 0;
  int fe_cnt = 0;
  int glitch_cnt = 0;
  logic mon_en = 1'b0;
  logic [3:0] sv_hist;
  logic [3:0] fe_hist;
  int base;

  ps2_key_state_decoder #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .CLOCK(clk), .RESET(rst), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
    .wasd(wasd), .arrows(arrows), .scan_code(scan_code),
    .scan_valid(scan_valid), .frame_error(frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters and the typematic glitch watcher, sampled mid-cycle.
  always @(negedge clk) begin
    if (scan_valid) sv_cnt <= sv_cnt + 1;
    if (frame_error) fe_cnt <= fe_cnt + 1;
    if (scan_valid && frame_error) glitch_cnt <= glitch_cnt + 1;
    if (mon_en && wasd != 4'b1001) glitch_cnt <= glitch_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    tick(HB);
    ps2_clk = 1'b0;
    tick(HB);
    ps2_clk = 1'b1;
  endtask

  // Full frame; the stop-bit edge records scan_valid/frame_error over the next four cycles.
  task automatic send_byte(input logic [7:0] b, input logic flip_par);
    logic par;
    par = ~(^b) ^ flip_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_data = 1'b1;
    tick(HB);
    ps2_clk = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      sv_hist[i] = scan_valid;
      fe_hist[i] = frame_error;
    end
    tick(HB - 4);
    ps2_clk = 1'b1;
    tick(HB);
  endtask

  task automatic send(input logic [7:0] b);
    send_byte(b, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    tick(3);
    check("rst_wasd", {28'd0, wasd}, 32'h0);
    check("rst_arrows", {28'd0, arrows}, 32'h0);
    check("rst_scan", {24'd0, scan_code}, 32'h0);
    check("rst_sv", {31'd0, scan_valid}, 32'h0);
    check("rst_fe", {31'd0, frame_error}, 32'h0);
    rst = 1'b0;
    tick(4);

    // First frame: scan_valid exactly on the third cycle after the stop edge
    send(8'h1D);
    check("sv_timing", {28'd0, sv_hist}, 32'h4);
    check("fe_quiet", {28'd0, fe_hist}, 32'h0);
    check("scan_1d", {24'd0, scan_code}, 32'h1D);
    check("make_w", {28'd0, wasd}, 32'h1);
    send(8'hF0);
    check("scan_f0", {24'd0, scan_code}, 32'hF0);
    check("brk_pending", {28'd0, wasd}, 32'h1);
    send(8'h1D);
    check("break_w", {28'd0, wasd}, 32'h0);

    // Extended arrows
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'h6B);
    check("arr_up_left", {28'd0, arrows}, 32'h3);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("arr_brk_up", {28'd0, arrows}, 32'h2);
    check("arr_wasd0", {28'd0, wasd}, 32'h0);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check("arr_clear", {28'd0, arrows}, 32'h0);

    // Typematic repeats must not glitch a held key
    send(8'h1D); send(8'h23);
    check("w_d", {28'd0, wasd}, 32'h9);
    mon_en = 1'b1;
    for (int i = 0; i < 12; i++) send(8'h1D);
    mon_en = 1'b0;
    check("typematic_glitch", glitch_cnt, 32'd0);
    check("typematic_wasd", {28'd0, wasd}, 32'h9);
    send(8'hF0); send(8'h23);
    check("break_d", {28'd0, wasd}, 32'h1);

    // Bad parity: error pulse, no byte, no key change
    base = sv_cnt;
    send_byte(8'h1C, 1'b1);
    check("par_fe", {28'd0, fe_hist}, 32'h4);
    check("par_sv", {28'd0, sv_hist}, 32'h0);
    check("par_sv_cnt", sv_cnt - base, 32'd0);
    check("par_wasd", {28'd0, wasd}, 32'h1);
    send(8'h1C);
    check("good_1c", {28'd0, wasd}, 32'h3);

    // Timeout of a five-bit partial frame
    base = fe_cnt;
    for (int i = 0; i < 5; i++) ps2_bit(1'b0);
    tick(TO / 2);
    check("to_early", fe_cnt - base, 32'd0);
    tick(TO * 2);
    check("to_once", fe_cnt - base, 32'd1);
    send(8'h1B);
    check("to_recover", {28'd0, wasd}, 32'h7);

    // BAT/overrun clears everything
    send(8'h23);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'h72); send(8'hE0); send(8'h74);
    check("all_wasd", {28'd0, wasd}, 32'hF);
    check("all_arrows", {28'd0, arrows}, 32'hF);
    send(8'hAA);
    check("bat_wasd", {28'd0, wasd}, 32'h0);
    check("bat_arrows", {28'd0, arrows}, 32'h0);
    check("bat_scan", {24'd0, scan_code}, 32'hAA);

    // Break of a key that is not held
    send(8'hF0); send(8'h1C);
    check("brk_unheld", {28'd0, wasd}, 32'h0);
    send(8'h1C);
    check("pre_rst", {28'd0, wasd}, 32'h2);

    // Reset in the middle of a frame
    base = fe_cnt;
    for (int i = 0; i < 6; i++) ps2_bit(1'b1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    check("mid_rst_wasd", {28'd0, wasd}, 32'h0);
    check("mid_rst_scan", {24'd0, scan_code}, 32'h0);
    check("mid_rst_fe", fe_cnt - base, 32'd0);
    send(8'h1D);
    check("post_rst_sv", {28'd0, sv_hist}, 32'h4);
    check("post_rst_scan", {24'd0, scan_code}, 32'h1D);
    check("post_rst_wasd", {28'd0, wasd}, 32'h1);
    check("sv_fe_overlap", glitch_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
